i2c_txn_sequencer: RTL and testbench

- Transaction-level controller for the I2C timing/SCL generator.
- Accepts one request at a time (7-bit address, R/W, byte count) and drives the generator's 5-bit command-state bus through START, ADDR, DATA and STOP.
- Advances on the generator's timing strobes; reports completion, NACK and progress to the top-level FSM.
- Runs in the 10 MHz domain produced by the generator.

---
 rtl/i2c_txn_sequencer_pkg.sv | 43 ++++
 rtl/i2c_txn_sequencer_if.sv | 18 +
 rtl/i2c_txn_sequencer_bit_counter.sv | 34 +++
 rtl/i2c_txn_sequencer.sv | 141 ++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_txn_sequencer_pkg.sv
// Shared definitions for the I2C transaction sequencer: command codes driven
// to the timing generator, sequencer state encoding and field widths.
// Optional macro I2C_SEQ_RESTART_EN adds the repeated-START state.
package i2c_txn_sequencer_pkg;

  localparam int unsigned LEN_W = 4;

  localparam logic [3:0] CMD_IDLE          = 4'b0000;
  localparam logic [3:0] CMD_START         = 4'b0001;
  localparam logic [3:0] CMD_DATA_TRANSFER = 4'b0010;
  localparam logic [3:0] CMD_RESTART       = 4'b0011;
  localparam logic [3:0] CMD_STOP          = 4'b0100;

  // Bit index of the acknowledge slot within a byte
  localparam logic [3:0] ACK_SLOT = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_DATA,
    ST_STOP
`ifdef I2C_SEQ_RESTART_EN
    , ST_RESTART
`endif
  } seq_state_t;

  function automatic logic [3:0] cmd_of(input seq_state_t s);
    logic [3:0] c;
    c = CMD_IDLE;
    case (s)
      ST_START:           c = CMD_START;
      ST_ADDR, ST_DATA:   c = CMD_DATA_TRANSFER;
      ST_STOP:            c = CMD_STOP;
`ifdef I2C_SEQ_RESTART_EN
      ST_RESTART:         c = CMD_RESTART;
`endif
      default:            c = CMD_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Request handshake between the top-level FSM (master) and the sequencer.
interface i2c_txn_sequencer_if;
  logic                                    i_req_valid;
  logic                                    o_req_ready;
  logic                                    i_req_rw;
  logic [6:0]                              i_req_addr;
  logic [i2c_txn_sequencer_pkg::LEN_W-1:0] i_req_len;

  modport master (
    output i_req_valid, i_req_rw, i_req_addr, i_req_len,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid, i_req_rw, i_req_addr, i_req_len,
    output o_req_ready
  );
endinterface

// File: rtl/i2c_txn_sequencer_bit_counter.sv
// Bit/byte counter for the sequencer: counts SCL periods within a byte,
// flags the end of the ACK slot and counts completed data bytes.
module i2c_bit_counter
  import i2c_txn_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_is_data,
  input  logic             i_bit_done,
  output logic [3:0]       o_bit_idx,
  output logic [LEN_W-1:0] o_byte_cnt,
  output logic             o_byte_end
);

  assign o_byte_end = i_en && i_bit_done && (o_bit_idx == ACK_SLOT);

  // Advance the bit index per SCL period; wrap after the ACK slot
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_bit_idx  <= '0;
      o_byte_cnt <= '0;
    end else if (i_en && i_bit_done) begin
      if (o_byte_end) begin
        o_bit_idx <= '0;
        if (i_is_data) o_byte_cnt <= o_byte_cnt + 1'b1;
      end else begin
        o_bit_idx <= o_bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Transaction-level sequencer for the I2C timing/SCL generator: takes one
// request at a time and walks the generator through START, ADDR, DATA, STOP.
// Optional macro I2C_SEQ_RESTART_EN: a request present at the end of STOP is
// taken immediately as a repeated START instead of returning to IDLE.
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  i2c_txn_sequencer_if.slave  req,
  output logic [4:0]          o_cmd_state,
  input  logic                i_t_HD_STA_done,
  input  logic                i_bit_done,
  input  logic                i_ack,
  output logic [3:0]          o_bit_idx,
  output logic [LEN_W-1:0]    o_byte_cnt,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_nack
);

  seq_state_t       state_q, state_d;
  logic             rw_q, rw_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             nack_flag_q, nack_flag_d;
  logic             done_d, nack_d;
  logic [3:0]       cmd_q;
  logic             ready;
  logic             cnt_clr;
  logic             byte_end;

  i2c_bit_counter u_bit_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (cnt_clr),
    .i_en       ((state_q == ST_ADDR) || (state_q == ST_DATA)),
    .i_is_data  (state_q == ST_DATA),
    .i_bit_done (i_bit_done),
    .o_bit_idx  (o_bit_idx),
    .o_byte_cnt (o_byte_cnt),
    .o_byte_end (byte_end)
  );

  // Next-state, request latching and completion reporting
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    len_d       = len_q;
    nack_flag_d = nack_flag_q;
    done_d      = 1'b0;
    nack_d      = 1'b0;
    ready       = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req.i_req_valid) begin
          state_d = ST_START;
          rw_d    = req.i_req_rw;
          len_d   = req.i_req_len;
        end
      end
      ST_START: begin
        if (i_t_HD_STA_done) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (byte_end) begin
          if (i_ack) begin
            nack_flag_d = 1'b1;
            state_d     = ST_STOP;
          end else if (len_q == '0) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_end) begin
          if (LEN_W'(o_byte_cnt + 1'b1) == len_q) state_d = ST_STOP;
          // On reads the ACK slot is ours to drive, so a high level is not a NACK
          if (!rw_q && i_ack) begin
            nack_flag_d = 1'b1;
            state_d     = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (i_bit_done) begin
          cnt_clr     = 1'b1;
          done_d      = 1'b1;
          nack_d      = nack_flag_q;
          nack_flag_d = 1'b0;
          state_d     = ST_IDLE;
`ifdef I2C_SEQ_RESTART_EN
          // Ready is offered only on the STOP-ending strobe so the previous
          // transaction's done/nack report lands on the same edge as accept
          ready = 1'b1;
          if (req.i_req_valid) begin
            state_d = ST_RESTART;
            rw_d    = req.i_req_rw;
            len_d   = req.i_req_len;
          end
`endif
        end
      end
`ifdef I2C_SEQ_RESTART_EN
      ST_RESTART: begin
        if (i_t_HD_STA_done) state_d = ST_ADDR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      len_q       <= '0;
      nack_flag_q <= 1'b0;
      o_done      <= 1'b0;
      o_nack      <= 1'b0;
      cmd_q       <= CMD_IDLE;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      len_q       <= len_d;
      nack_flag_q <= nack_flag_d;
      o_done      <= done_d;
      o_nack      <= nack_d;
      cmd_q       <= cmd_of(state_q);
    end
  end

  assign req.o_req_ready = ready;
  assign o_cmd_state     = {1'b0, cmd_q};
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer: a behavioural generator model
// answers the sequencer's command bus with strobes and ACK levels, and a
// transaction-level reference predicts bytes moved, NACK reporting and the
// command sequence.
module tb_i2c_txn_sequencer;
  import i2c_txn_sequencer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       cmd;
  logic             hd, bd, ack;
  logic [3:0]       bit_idx;
  logic [LEN_W-1:0] byte_cnt;
  logic             busy, done, nack;

  always #5 clk = ~clk;

  i2c_txn_sequencer_if rq();

  i2c_txn_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .req             (rq),
    .o_cmd_state     (cmd),
    .i_t_HD_STA_done (hd),
    .i_bit_done      (bd),
    .i_ack           (ack),
    .o_bit_idx       (bit_idx),
    .o_byte_cnt      (byte_cnt),
    .o_busy          (busy),
    .o_done          (done),
    .o_nack          (nack)
  );

  int checks = 0;
  int failures = 0;

  // Observations gathered every cycle
  logic [63:0] seq_code;
  int          seq_last;
  int          done_cnt, stray_nack, max_byte;
  int          nack_log[$];

  // Driver results
  int strobes, bit_idx_bad, busy_low;
  bit timed_out, aborted;

  task automatic step();
    @(posedge clk);
    #1;
    if (int'(cmd) != seq_last) begin
      seq_code = {seq_code[59:0], cmd[3:0]};
      seq_last = int'(cmd);
    end
    if (done) begin
      done_cnt++;
      nack_log.push_back(int'(nack));
    end else if (nack) begin
      stray_nack++;
    end
    if (int'(byte_cnt) > max_byte) max_byte = int'(byte_cnt);
  endtask

  // Reference: acks[0] is the address slot, acks[b] the slot of data byte b
  function automatic void model(input bit rw, input int len, input logic [15:0] acks,
                                output int nbytes, output bit nk);
    nbytes = 0;
    nk     = 1'b0;
    if (acks[0]) begin
      nk = 1'b1;
      return;
    end
    for (int b = 1; b <= len; b++) begin
      nbytes = b;
      if (!rw && acks[4'(b)]) begin
        nk = 1'b1;
        return;
      end
    end
  endfunction

  function automatic logic [15:0] rand_acks();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4'(i)] = ($urandom_range(0, 4) == 0);
    return r;
  endfunction

  // Behavioural timing generator: answers START/RESTART with a hold strobe,
  // clocks bits during transfers and ends STOP with one strobe.
  task automatic drive(input bit chain,
                       input bit rw0, input int len0, input logic [15:0] ak0,
                       input bit rw1, input int len1, input logic [15:0] ak1,
                       input int abort_at);
    int txn, stb, gap, tail, last;
    bit hd_done, stop_done, acc_pending;
    logic [15:0] akv;
    seq_code = 64'(cmd[3:0]);
    seq_last = int'(cmd);
    done_cnt = 0; stray_nack = 0; max_byte = 0; nack_log.delete();
    strobes = 0; bit_idx_bad = 0; busy_low = 0; timed_out = 1'b1; aborted = 1'b0;
    last = chain ? 1 : 0;
    txn = 0; stb = 0; gap = 0; tail = 0;
    hd_done = 1'b0; stop_done = 1'b0; acc_pending = 1'b0;
    rq.i_req_valid = 1'b1;
    rq.i_req_rw    = rw0;
    rq.i_req_addr  = 7'($urandom);
    rq.i_req_len   = LEN_W'(len0);
    for (int w = 0; w < 50 && !rq.o_req_ready; w++) step();
    step();
    rq.i_req_valid = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bd = 1'b0;
      hd = 1'b0;
      if (acc_pending) begin
        rq.i_req_valid = 1'b0;
        txn = 1; stb = 0; hd_done = 1'b0; stop_done = 1'b0; acc_pending = 1'b0;
      end
      if (bit_idx !== 4'(stb % 9)) bit_idx_bad++;
      if (!busy && !(stop_done && txn == last)) busy_low++;
      if (abort_at >= 0 && stb == abort_at) begin
        aborted = 1'b1;
        timed_out = 1'b0;
        return;
      end
      if (stop_done && txn == last) begin
        tail++;
        if (tail >= 4) begin
          timed_out = 1'b0;
          return;
        end
      end
      gap++;
      akv = (txn == 0) ? ak0 : ak1;
      if ((cmd == {1'b0, CMD_START} || cmd == {1'b0, CMD_RESTART}) && !hd_done && gap >= 2) begin
        hd = 1'b1; hd_done = 1'b1; gap = 0;
      end else if (cmd == {1'b0, CMD_DATA_TRANSFER} && gap >= 3) begin
        bd  = 1'b1;
        ack = (stb % 9 == 8) ? akv[4'(stb / 9)] : 1'($urandom);
        stb++; strobes++; gap = 0;
      end else if (cmd == {1'b0, CMD_STOP} && !stop_done && gap >= 3) begin
        bd = 1'b1; stop_done = 1'b1; gap = 0;
        if (chain && txn == 0) begin
          rq.i_req_valid = 1'b1;
          rq.i_req_rw    = rw1;
          rq.i_req_addr  = 7'($urandom);
          rq.i_req_len   = LEN_W'(len1);
        end
      end
      #1;
      if (rq.i_req_valid && rq.o_req_ready) acc_pending = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (cmd !== 5'd0)        begin failures++; $display("FAIL reset_cmd got %h want 00", cmd); end
    checks++; if (rq.o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", rq.o_req_ready); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || nack !== 1'b0) begin failures++; $display("FAIL reset_done_nack got %b%b want 00", done, nack); end
    checks++; if (bit_idx !== 4'd0 || byte_cnt !== '0) begin failures++; $display("FAIL reset_counters got %0d/%0d want 0/0", bit_idx, byte_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ignored_strobes();
    for (int i = 0; i < 6; i++) begin
      bd = 1'($urandom);
      hd = 1'($urandom);
      step();
      checks++;
      if ({busy, cmd, bit_idx, done} !== '0) begin
        failures++;
        $display("FAIL idle_ignore busy=%b cmd=%h bit_idx=%0d done=%b want all 0", busy, cmd, bit_idx, done);
      end
    end
    bd = 1'b0;
    hd = 1'b0;
    step();
  endtask

  task automatic test_transaction(input string name, input bit rw, input int len, input logic [15:0] acks);
    int nb, got_nack;
    bit nk;
    model(rw, len, acks, nb, nk);
    drive(1'b0, rw, len, acks, 1'b0, 0, '0, -1);
    got_nack = (nack_log.size() > 0) ? nack_log[0] : -1;
    checks++; if (timed_out)                    begin failures++; $display("FAIL %s timeout got 1 want 0", name); end
    checks++; if (seq_code !== 64'h01240)       begin failures++; $display("FAIL %s cmd_seq got %h want 01240", name, seq_code); end
    checks++; if (strobes != 9 * (1 + nb))      begin failures++; $display("FAIL %s strobes got %0d want %0d", name, strobes, 9 * (1 + nb)); end
    checks++; if (max_byte != nb)               begin failures++; $display("FAIL %s byte_cnt got %0d want %0d", name, max_byte, nb); end
    checks++; if (done_cnt != 1)                begin failures++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); end
    checks++; if (got_nack != int'(nk))         begin failures++; $display("FAIL %s nack got %0d want %0d", name, got_nack, nk); end
    checks++; if (stray_nack != 0)              begin failures++; $display("FAIL %s stray_nack got %0d want 0", name, stray_nack); end
    checks++; if (bit_idx_bad != 0)             begin failures++; $display("FAIL %s bit_idx_track got %0d bad want 0", name, bit_idx_bad); end
    checks++; if ({rq.o_req_ready, busy, byte_cnt, bit_idx} !== {1'b1, 1'b0, LEN_W'(0), 4'd0}) begin
      failures++;
      $display("FAIL %s end_idle ready=%b busy=%b byte_cnt=%0d bit_idx=%0d want 1/0/0/0", name, rq.o_req_ready, busy, byte_cnt, bit_idx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      test_transaction("random", 1'($urandom), int'($urandom_range(0, 5)), rand_acks());
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 3, 16'h0000, 1'b0, 0, '0, 13);
    checks++; if (!aborted)           begin failures++; $display("FAIL rst_mid reached_bit4 got 0 want 1"); end
    checks++; if (bit_idx !== 4'd4)   begin failures++; $display("FAIL rst_mid pre_bit_idx got %0d want 4", bit_idx); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (cmd !== 5'd0)       begin failures++; $display("FAIL rst_mid cmd got %h want 00", cmd); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_mid busy got %b want 0", busy); end
    checks++; if (rq.o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid ready got %b want 1", rq.o_req_ready); end
    checks++; if (bit_idx !== 4'd0 || byte_cnt !== '0) begin failures++; $display("FAIL rst_mid counters got %0d/%0d want 0/0", bit_idx, byte_cnt); end
    done_cnt = 0;
    repeat (5) step();
    checks++; if (done_cnt != 0)      begin failures++; $display("FAIL rst_mid done_pulses got %0d want 0", done_cnt); end
    checks++; if (cmd !== 5'd0)       begin failures++; $display("FAIL rst_mid no_stop cmd got %h want 00", cmd); end
  endtask

  task automatic test_back_to_back();
    bit rw0, rw1, nk0, nk1, low_exp;
    int len0, len1, nb0, nb1, n0, n1;
    logic [15:0] a0, a1;
    logic [63:0] seq_exp;
`ifdef I2C_SEQ_RESTART_EN
    seq_exp = 64'h01243240;
    low_exp = 1'b0;
`else
    seq_exp = 64'h012401240;
    low_exp = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      rw0 = 1'($urandom); len0 = int'($urandom_range(0, 3)); a0 = rand_acks();
      rw1 = 1'($urandom); len1 = int'($urandom_range(0, 3)); a1 = rand_acks();
      model(rw0, len0, a0, nb0, nk0);
      model(rw1, len1, a1, nb1, nk1);
      drive(1'b1, rw0, len0, a0, rw1, len1, a1, -1);
      n0 = (nack_log.size() > 0) ? nack_log[0] : -1;
      n1 = (nack_log.size() > 1) ? nack_log[1] : -1;
      checks++; if (timed_out)                 begin failures++; $display("FAIL b2b timeout got 1 want 0"); end
      checks++; if (seq_code !== seq_exp)      begin failures++; $display("FAIL b2b cmd_seq got %h want %h", seq_code, seq_exp); end
      checks++; if (done_cnt != 2)             begin failures++; $display("FAIL b2b done_pulses got %0d want 2", done_cnt); end
      checks++; if (n0 != int'(nk0) || n1 != int'(nk1)) begin failures++; $display("FAIL b2b nacks got %0d,%0d want %0d,%0d", n0, n1, nk0, nk1); end
      checks++; if (strobes != 9 * (2 + nb0 + nb1)) begin failures++; $display("FAIL b2b strobes got %0d want %0d", strobes, 9 * (2 + nb0 + nb1)); end
      checks++; if ((busy_low > 0) != low_exp) begin failures++; $display("FAIL b2b busy_gap got %0d low cycles want gap=%b", busy_low, low_exp); end
      checks++; if (bit_idx_bad != 0)          begin failures++; $display("FAIL b2b bit_idx_track got %0d bad want 0", bit_idx_bad); end
    end
  endtask

  initial begin
    rst = 1'b1; bd = 1'b0; hd = 1'b0; ack = 1'b1;
    rq.i_req_valid = 1'b0; rq.i_req_rw = 1'b0; rq.i_req_addr = '0; rq.i_req_len = '0;
    seq_code = '0; seq_last = 0; done_cnt = 0; stray_nack = 0; max_byte = 0;
    test_reset();
    test_ignored_strobes();
    test_transaction("wr_len2_ack",      1'b0, 2,  16'h0000);
    test_transaction("wr_addr_nack",     1'b0, 2,  16'h0001);
    test_transaction("probe_len0",       1'b0, 0,  16'h0000);
    test_transaction("rd_len3_last_hi",  1'b1, 3,  16'h0008);
    test_transaction("wr_len3_nack_b2",  1'b0, 3,  16'h0004);
    test_transaction("wr_len1_nack_last",1'b0, 1,  16'h0002);
    test_transaction("wr_len15_max",     1'b0, 15, 16'h0000);
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim time exceeded limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
